// File: rtl/axis_vga_sink.sv
// axis_vga_sink: buffers an RGB565 AXI4-Stream framebuffer readout and replays it on the VGA active-video strobe.
// Optional feature macro AXIS_VGA_SINK_BLANK_EN: rgb_o is forced to zero in every cycle where de_o is low.
module axis_vga_sink #(
    parameter int unsigned H_RES         = 800,
    parameter int unsigned V_RES         = 600,
    parameter int unsigned FIFO_DEPTH    = 512,
    parameter int unsigned PREFILL_LEVEL = 256,
    parameter logic [15:0] UNDERFLOW_RGB = 16'hF81F
) (
    input  logic        axi_clk_i,
    input  logic        axi_rst_ni,
    input  logic [15:0] s_axis_video_tdata,
    input  logic        s_axis_video_tvalid,
    output logic        s_axis_video_tready,
    input  logic        s_axis_video_tlast,
    input  logic        s_axis_video_tuser,
    input  logic        de_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        frame_start_i,
    input  logic        err_clear_i,
    output logic [15:0] rgb_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        underflow_o,
    output logic        sync_err_o,
    output logic [1:0]  state_o
);
    localparam int unsigned FRAME = H_RES * V_RES;
    localparam int unsigned CNT_W = $clog2(FRAME + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = AW + 1;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt;
    logic [15:0]      r_rgb;
    logic             r_tready, r_underflow, r_sync_err, r_de, r_hsync, r_vsync;
    logic             w_accept, w_last_exp, w_last_bad, w_empty;
    logic             w_push, w_pop, w_flush, w_err_set, w_uf_set, w_rd_clr, w_rd_inc;
    logic             w_unused;

    assign w_accept   = s_axis_video_tvalid && r_tready;
    assign w_last_exp = (r_wr_cnt == CNT_W'(FRAME - 1));
    assign w_last_bad = (s_axis_video_tlast != w_last_exp);
    assign w_empty    = (r_count == '0);
    assign w_unused   = s_axis_video_tuser;

    // Next state and per-cycle FIFO/counter actions; any framing error flushes back to SYNC.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_err_set   = 1'b0;
        w_uf_set    = 1'b0;
        w_rd_clr    = 1'b0;
        w_rd_inc    = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_accept && s_axis_video_tlast) begin
                    w_state_nxt = ST_PREFILL;
                    w_flush     = 1'b1;
                end
            end
            ST_PREFILL: begin
                if (w_accept) begin
                    if (w_last_bad) w_err_set = 1'b1;
                    else            w_push    = 1'b1;
                end
                if (frame_start_i && (r_count >= OCC_W'(PREFILL_LEVEL)))
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_last_bad) w_err_set = 1'b1;
                    else            w_push    = 1'b1;
                end
                if (de_i) begin
                    w_rd_inc = 1'b1;
                    if (w_empty) w_uf_set = 1'b1;
                    else         w_pop    = 1'b1;
                end
                if (frame_start_i) begin
                    if (r_rd_cnt == CNT_W'(FRAME)) w_rd_clr  = 1'b1;
                    else                           w_err_set = 1'b1;
                end
            end
            default: w_state_nxt = ST_SYNC;
        endcase
        if (w_err_set) begin
            w_state_nxt = ST_SYNC;
            w_flush     = 1'b1;
        end
        w_count_nxt = w_flush ? '0 : (r_count + OCC_W'(w_push) - OCC_W'(w_pop));
    end

    always_ff @(posedge axi_clk_i or negedge axi_rst_ni) begin
        if (!axi_rst_ni) r_state <= ST_SYNC;
        else             r_state <= w_state_nxt;
    end

    // FIFO bookkeeping; TREADY is registered from next-cycle state and occupancy.
    always_ff @(posedge axi_clk_i or negedge axi_rst_ni) begin
        if (!axi_rst_ni) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_tready <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_tready <= (w_state_nxt == ST_SYNC) || (w_count_nxt != OCC_W'(FIFO_DEPTH));
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_wr_cnt <= w_last_exp ? '0 : (r_wr_cnt + 1'b1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_rd_clr)      r_rd_cnt <= CNT_W'(w_rd_inc);
                else if (w_rd_inc) r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge axi_clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= s_axis_video_tdata;
    end

    // Pixel/sync output stage and sticky error flags (a new event beats a same-cycle clear).
    always_ff @(posedge axi_clk_i or negedge axi_rst_ni) begin
        if (!axi_rst_ni) begin
            r_rgb       <= '0;
            r_de        <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_underflow <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_de        <= de_i;
            r_hsync     <= hsync_i;
            r_vsync     <= vsync_i;
            r_underflow <= w_uf_set || (r_underflow && !err_clear_i);
            r_sync_err  <= w_err_set || (r_sync_err && !err_clear_i);
            if (w_pop)         r_rgb <= r_mem[r_rd_ptr];
            else if (w_uf_set) r_rgb <= UNDERFLOW_RGB;
`ifdef AXIS_VGA_SINK_BLANK_EN
            else if (!de_i)    r_rgb <= '0;
`endif
        end
    end

    assign s_axis_video_tready = r_tready;
    assign rgb_o               = r_rgb;
    assign de_o                = r_de;
    assign hsync_o             = r_hsync;
    assign vsync_o             = r_vsync;
    assign underflow_o         = r_underflow;
    assign sync_err_o          = r_sync_err;
    assign state_o             = r_state;

endmodule

// File: tb/tb_axis_vga_sink.sv
// Self-checking bench for axis_vga_sink (H_RES=4, V_RES=2, FIFO_DEPTH=8, PREFILL_LEVEL=4).
module tb_axis_vga_sink;
    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic        chk;
        logic [15:0] v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] tdata;
    logic        tvalid, tready, tlast, tuser;
    logic        de, hs, vs, fs, clr;
    logic [15:0] rgb;
    logic        de_o, hs_o, vs_o, uf, serr;
    logic [1:0]  st;
    int          checks;
    int          errors;
    beat_t       bq[$];
    exp_t        eq[$];

    axis_vga_sink #(
        .H_RES(4), .V_RES(2), .FIFO_DEPTH(8), .PREFILL_LEVEL(4), .UNDERFLOW_RGB(16'hF81F)
    ) dut (
        .axi_clk_i(clk), .axi_rst_ni(rst_n),
        .s_axis_video_tdata(tdata), .s_axis_video_tvalid(tvalid), .s_axis_video_tready(tready),
        .s_axis_video_tlast(tlast), .s_axis_video_tuser(tuser),
        .de_i(de), .hsync_i(hs), .vsync_i(vs), .frame_start_i(fs), .err_clear_i(clr),
        .rgb_o(rgb), .de_o(de_o), .hsync_o(hs_o), .vsync_o(vs_o),
        .underflow_o(uf), .sync_err_o(serr), .state_o(st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One clock: present stream head and strobes, then score delayed syncs and popped pixels.
    task automatic tick(input logic d, input logic f, input logic c);
        logic acc, h, v;
        exp_t e;
        h = 1'($urandom);
        v = 1'($urandom);
        de = d; fs = f; clr = c; hs = h; vs = v; tuser = 1'($urandom);
        if (bq.size() != 0) begin
            tvalid = 1'b1; tdata = bq[0].d; tlast = bq[0].l;
        end else begin
            tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        end
        acc = tvalid && tready;
        @(posedge clk); #1;
        if (acc) void'(bq.pop_front());
        checks++;
        if (de_o !== d || hs_o !== h || vs_o !== v) begin
            errors++;
            $display("FAIL sync_delay got de/hs/vs=%b%b%b exp %b%b%b", de_o, hs_o, vs_o, d, h, v);
        end
        if (d && eq.size() != 0) begin
            e = eq.pop_front();
            if (e.chk) begin
                checks++;
                if (rgb !== e.v) begin
                    errors++;
                    $display("FAIL rgb_out got %h exp %h", rgb, e.v);
                end
            end
        end
    endtask

    task automatic de_px(input logic [15:0] v);
        eq.push_back('{chk: 1'b1, v: v});
        tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic add_junk();
        for (int i = 0; i < 3; i++) bq.push_back('{d: 16'hDEA0 + 16'(i), l: (i == 2)});
    endtask

    task automatic add_frame(input logic [15:0] base);
        for (int i = 0; i < 8; i++) bq.push_back('{d: base + 16'(i), l: (i == 7)});
    endtask

    task automatic drain(input int max, input string name);
        int n;
        n = 0;
        while (bq.size() != 0 && n < max) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (bq.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d beats left exp 0", name, bq.size());
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        de = 0; hs = 0; vs = 0; fs = 0; clr = 0; tvalid = 0; tdata = '0; tlast = 0; tuser = 0;
        bq.delete();
        eq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic bring_up(input logic [15:0] base);
        reset_dut();
        add_junk();
        add_frame(base);
        drain(40, "bringup_drain");
        checks++;
        if (st !== 2'd1) begin errors++; $display("FAIL bringup_prefill got %0d exp 1", st); end
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (st !== 2'd2) begin errors++; $display("FAIL bringup_run got %0d exp 2", st); end
    endtask

    task automatic test_reset();
        reset_dut();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rgb !== 16'h0 || de_o !== 0 || hs_o !== 0 || vs_o !== 0 || uf !== 0 || serr !== 0 ||
            st !== 2'd0 || tready !== 0) begin
            errors++;
            $display("FAIL reset_values got rgb=%h de=%b st=%0d tready=%b uf=%b serr=%b exp 0", rgb, de_o, st, tready, uf, serr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (tready !== 1'b1 || st !== 2'd0) begin
            errors++;
            $display("FAIL sync_tready got tready=%b st=%0d exp 1 0", tready, st);
        end
    endtask

    task automatic test_basic();
        bring_up(16'h0001);
        for (int i = 1; i <= 8; i++) de_px(16'(i));
        checks++;
        if (serr !== 0 || uf !== 0) begin
            errors++;
            $display("FAIL basic_flags got serr=%b uf=%b exp 0 0", serr, uf);
        end
    endtask

    task automatic test_underflow();
        bring_up(16'h0001);
        for (int i = 1; i <= 8; i++) de_px(16'(i));
        bq.push_back('{d: 16'h0011, l: 1'b0});
        bq.push_back('{d: 16'h0012, l: 1'b0});
        drain(10, "uf_drain");
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (st !== 2'd2 || serr !== 0) begin
            errors++;
            $display("FAIL uf_frame_ok got st=%0d serr=%b exp 2 0", st, serr);
        end
        de_px(16'h0011);
        de_px(16'h0012);
        checks++;
        if (uf !== 0) begin errors++; $display("FAIL uf_early got %b exp 0", uf); end
        de_px(16'hF81F);
        de_px(16'hF81F);
        checks++;
        if (uf !== 1) begin errors++; $display("FAIL uf_set got %b exp 1", uf); end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (uf !== 0) begin errors++; $display("FAIL uf_clear got %b exp 0", uf); end
    endtask

    task automatic test_tlast_err();
        reset_dut();
        add_junk();
        for (int i = 0; i < 5; i++) bq.push_back('{d: 16'h0021 + 16'(i), l: (i == 4)});
        drain(30, "tlast_drain");
        checks++;
        if (serr !== 1 || st !== 2'd0 || tready !== 1) begin
            errors++;
            $display("FAIL tlast_err got serr=%b st=%0d tready=%b exp 1 0 1", serr, st, tready);
        end
        bq.push_back('{d: 16'h0031, l: 1'b0});
        bq.push_back('{d: 16'h0032, l: 1'b1});
        drain(10, "resync_drain");
        checks++;
        if (st !== 2'd1) begin errors++; $display("FAIL resync_state got %0d exp 1", st); end
        add_frame(16'h0061);
        drain(20, "tlast_frame_drain");
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) de_px(16'h0061 + 16'(i));
        checks++;
        if (serr !== 1) begin errors++; $display("FAIL serr_sticky got %b exp 1", serr); end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (serr !== 0) begin errors++; $display("FAIL serr_clear got %b exp 0", serr); end
    endtask

    task automatic test_frame_len();
        bring_up(16'h0001);
        for (int i = 1; i <= 6; i++) de_px(16'(i));
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (serr !== 1 || st !== 2'd0 || tready !== 1) begin
            errors++;
            $display("FAIL len_err got serr=%b st=%0d tready=%b exp 1 0 1", serr, st, tready);
        end
        bq.push_back('{d: 16'h007F, l: 1'b1});
        add_frame(16'h0041);
        drain(20, "len_drain");
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (st !== 2'd2) begin errors++; $display("FAIL len_rerun got %0d exp 2", st); end
        for (int i = 0; i < 8; i++) de_px(16'h0041 + 16'(i));
    endtask

    task automatic test_back_to_back();
        reset_dut();
        add_junk();
        for (int i = 0; i < 10; i++) bq.push_back('{d: 16'h0051 + 16'(i), l: (i == 7)});
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (tready !== 0 || bq.size() != 2 || st !== 2'd1) begin
            errors++;
            $display("FAIL bp_full got tready=%b left=%0d st=%0d exp 0 2 1", tready, bq.size(), st);
        end
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) de_px(16'h0051 + 16'(i));
        checks++;
        if (bq.size() != 0 || uf !== 0 || serr !== 0) begin
            errors++;
            $display("FAIL bp_resume got left=%0d uf=%b serr=%b exp 0 0 0", bq.size(), uf, serr);
        end
    endtask

    task automatic test_reset_mid();
        bring_up(16'h0001);
        for (int i = 1; i <= 3; i++) de_px(16'(i));
        de = 1'b1; hs = 1'b1; vs = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rgb !== 16'h0 || de_o !== 0 || hs_o !== 0 || vs_o !== 0 || uf !== 0 || serr !== 0 ||
            st !== 2'd0 || tready !== 0) begin
            errors++;
            $display("FAIL mid_reset got rgb=%h de=%b st=%0d tready=%b exp 0", rgb, de_o, st, tready);
        end
        test_basic();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        test_reset();
        test_basic();
        test_underflow();
        test_tlast_err();
        test_frame_len();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
